// File: rtl/mux_sel_scanner_pkg.sv
// Shared types and constants for the mux select scanner.
// Holds the FSM encoding and the fixed scan geometry.
package mux_sel_scanner_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam logic [1:0] SEL_LAST = 2'd3;
  localparam int         DATA_W   = 4;

endpackage

// File: rtl/mux_sel_scanner_settle.sv
// Settle timer: counts cycles a select value has been held.
// done marks the last settle cycle; the count then clears itself.
module settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic done
);

  localparam int CNT_W =
    ($clog2(SETTLE_CYCLES) > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign done = (cnt == CNT_LAST);

  // Count up while enabled; restart on clear or after the last cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      if (done) cnt <= '0;
      else      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux_sel_scanner.sv
// Drives a 4:1 mux through all channels and assembles the samples.
// Single-shot or continuous scans, with start/busy and abort.
module mux_sel_scanner
  import mux_sel_scanner_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  input  logic              mux_out,
  output logic [1:0]        select,
  output logic              busy,
  output logic [DATA_W-1:0] data,
  output logic              data_valid
);

  state_t            state, state_n;
  logic [1:0]        select_n;
  logic              busy_n;
  logic [DATA_W-1:0] capture, capture_n;
  logic [DATA_W-1:0] data_n;
  logic              valid_n;
  logic              t_clear, t_en, t_done;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(t_clear),
    .en   (t_en),
    .done (t_done)
  );

  // Next-state and next-output decode; abort outranks everything.
  always_comb begin
    state_n   = state;
    select_n  = select;
    busy_n    = busy;
    capture_n = capture;
    data_n    = data;
    valid_n   = 1'b0;
    t_clear   = 1'b0;
    t_en      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        select_n = 2'd0;
        t_clear  = 1'b1;
        if (start && !abort) begin
          state_n   = ST_SCAN;
          busy_n    = 1'b1;
          capture_n = '0;
        end
      end
      ST_SCAN: begin
        if (abort) begin
          state_n  = ST_IDLE;
          busy_n   = 1'b0;
          select_n = 2'd0;
          t_clear  = 1'b1;
        end else begin
          t_en = 1'b1;
          if (t_done) begin
            capture_n[select] = mux_out;
            if (select != SEL_LAST) begin
              select_n = select + 2'd1;
            end else begin
              data_n   = {mux_out, capture[2:0]};
              valid_n  = 1'b1;
              select_n = 2'd0;
              if (continuous) begin
                capture_n = '0;
              end else begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
              end
            end
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Register FSM state, select lines, samples and outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      select     <= 2'd0;
      busy       <= 1'b0;
      capture    <= '0;
      data       <= '0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_n;
      select     <= select_n;
      busy       <= busy_n;
      capture    <= capture_n;
      data       <= data_n;
      data_valid <= valid_n;
    end
  end

endmodule
